// File: rtl/stdp_dt_tracker.sv
// stdp_dt_tracker: measures the pre-to-post spike interval (in ticks) used
// as the address of an STDP depression LUT. Each pre spike arms an interval
// counter; the next post spike either produces an accepted dt (inside
// [WINDOW_MIN, WINDOW_MAX]) or bumps a saturating reject counter.
// Optional build macro: DT_TIMEOUT_EN -- drop a pending pre spike once the
// interval passes WINDOW_MAX, so late post spikes are ignored, not rejected.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | no pending pre spike; post spikes are ignored
// ARMED  | pre spike pending; interval counter advances on each tick
module stdp_dt_tracker #(
  parameter int WINDOW_MIN = 2,
  parameter int WINDOW_MAX = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        pre_spike,
  input  logic        post_spike,
  output logic [7:0]  dt,
  output logic        dt_valid,
  output logic        lut_valid,
  output logic [15:0] reject_cnt
);

  typedef enum logic {S_IDLE = 1'b0, S_ARMED = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [7:0]  w_n;
  logic        w_in_win;
  logic        w_accept;
  logic        w_reject;
  logic        w_timeout;
  logic [7:0]  r_dt;
  logic        r_dt_valid;
  logic        r_lut_valid;
  logic [15:0] r_reject_cnt;

  // Interval seen by an event on this tick: one more than the stored count,
  // so a post one tick after the pre gives n=1.
  assign w_n      = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;
  assign w_in_win = (32'(w_n) >= WINDOW_MIN) && (32'(w_n) <= WINDOW_MAX);

`ifdef DT_TIMEOUT_EN
  assign w_timeout = (32'(w_n) == WINDOW_MAX + 1);
`else
  assign w_timeout = 1'b0;
`endif

  // State and interval counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: a pre spike always re-arms after the post has been judged
  // against the old interval, so coincident pre+post ends ARMED at zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (tick) begin
      if (pre_spike) begin
        w_state_nxt = S_ARMED;
        w_cnt_nxt   = 8'd0;
      end else if (r_state == S_ARMED) begin
        w_cnt_nxt = w_n;
        if (post_spike || w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
    end
  end

  // Event classification of a post spike evaluated in ARMED
  always_comb begin
    w_accept = 1'b0;
    w_reject = 1'b0;
    if (tick && post_spike && (r_state == S_ARMED)) begin
      w_accept = w_in_win;
      w_reject = !w_in_win;
    end
  end

  // Output datapath: dt capture, valid pulse, LUT-aligned valid, reject count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dt         <= 8'd0;
      r_dt_valid   <= 1'b0;
      r_lut_valid  <= 1'b0;
      r_reject_cnt <= 16'd0;
    end else begin
      r_dt_valid  <= w_accept;
      r_lut_valid <= r_dt_valid;
      if (w_accept) begin
        r_dt <= w_n;
      end
      if (w_reject && (r_reject_cnt != 16'hFFFF)) begin
        r_reject_cnt <= r_reject_cnt + 16'd1;
      end
    end
  end

  assign dt         = r_dt;
  assign dt_valid   = r_dt_valid;
  assign lut_valid  = r_lut_valid;
  assign reject_cnt = r_reject_cnt;

endmodule

// File: tb/tb_stdp_dt_tracker.sv
// Bench for stdp_dt_tracker: directed spike sequences; expected dt values are
// queued when the deciding post spike is issued and popped by a monitor on
// every dt_valid pulse. Honours DT_TIMEOUT_EN if defined for the build.
module tb_stdp_dt_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        pre_spike;
  logic        post_spike;
  logic [7:0]  dt;
  logic        dt_valid;
  logic        lut_valid;
  logic [15:0] reject_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q[$];
  logic        prev_dv = 1'b0;

  always #5 clk = ~clk;

  stdp_dt_tracker #(.WINDOW_MIN(2), .WINDOW_MAX(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .pre_spike (pre_spike),
    .post_spike(post_spike),
    .dt        (dt),
    .dt_valid  (dt_valid),
    .lut_valid (lut_valid),
    .reject_cnt(reject_cnt)
  );

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // One clock with the given tick/spike inputs
  task automatic cyc(input logic t, input logic p, input logic q);
    tick = t; pre_spike = p; post_spike = q;
    @(posedge clk);
    #1;
    tick = 1'b0; pre_spike = 1'b0; post_spike = 1'b0;
  endtask

  task automatic tk(input logic p, input logic q);
    cyc(1'b1, p, q);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tk(1'b0, 1'b0);
  endtask

  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (dt_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_dt_valid", int'(dt), -1);
        end else begin
          e = exp_q.pop_front();
          chk("dt_value", int'(dt), int'(e));
        end
      end
      if (prev_dv || lut_valid) chk("lut_valid_align", int'(lut_valid), int'(prev_dv));
      prev_dv = dt_valid;
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; pre_spike = 1'b0; post_spike = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_dt", int'(dt), 0);
    chk("rst_dt_valid", int'(dt_valid), 0);
    chk("rst_lut_valid", int'(lut_valid), 0);
    chk("rst_reject_cnt", int'(reject_cnt), 0);

    // post in IDLE is ignored
    tk(1'b0, 1'b1);
    chk("idle_post_reject", int'(reject_cnt), 0);

    // pre at tick 10, post at tick 15 -> dt=5
    idle(10);
    tk(1'b1, 1'b0);
    idle(4);
    exp_q.push_back(8'd5);
    tk(1'b0, 1'b1);
    idle(3);
    chk("dt_hold_5", int'(dt), 5);
    // back in IDLE: another post is ignored
    tk(1'b0, 1'b1);
    chk("post_after_pair_reject", int'(reject_cnt), 0);

    // n=1 rejected
    tk(1'b1, 1'b0);
    tk(1'b0, 1'b1);
    chk("n1_reject", int'(reject_cnt), 1);
    // n=20 accepted (upper bound)
    tk(1'b1, 1'b0);
    idle(19);
    exp_q.push_back(8'd20);
    tk(1'b0, 1'b1);
    // n=2 accepted (lower bound)
    tk(1'b1, 1'b0);
    idle(1);
    exp_q.push_back(8'd2);
    tk(1'b0, 1'b1);
    // n=21 rejected
    tk(1'b1, 1'b0);
    idle(20);
    tk(1'b0, 1'b1);
    chk("n21_reject", int'(reject_cnt), 2);

    // coincident pre+post at n=4, then post 3 ticks later
    tk(1'b1, 1'b0);
    idle(3);
    exp_q.push_back(8'd4);
    tk(1'b1, 1'b1);
    idle(2);
    exp_q.push_back(8'd3);
    tk(1'b0, 1'b1);
    chk("coincide_reject", int'(reject_cnt), 2);

    // spikes with tick=0 have no effect while ARMED and do not advance n
    tk(1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    idle(2);
    exp_q.push_back(8'd3);
    tk(1'b0, 1'b1);
    chk("tick0_reject", int'(reject_cnt), 2);
    // tick=0 spikes in IDLE do not arm
    cyc(1'b0, 1'b1, 1'b0);
    idle(3);
    tk(1'b0, 1'b1);
    chk("tick0_no_arm", int'(reject_cnt), 2);

    // pre at 0, post at 30
    tk(1'b1, 1'b0);
    idle(29);
    tk(1'b0, 1'b1);
`ifdef DT_TIMEOUT_EN
    chk("late_post_timeout", int'(reject_cnt), 2);
`else
    chk("late_post_reject", int'(reject_cnt), 3);
`endif

    // reset while ARMED, with tick/pre driven during reset
    tk(1'b1, 1'b0);
    idle(6);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    chk("rst2_dt", int'(dt), 0);
    chk("rst2_dt_valid", int'(dt_valid), 0);
    chk("rst2_lut_valid", int'(lut_valid), 0);
    chk("rst2_reject_cnt", int'(reject_cnt), 0);
    tk(1'b0, 1'b1);
    idle(2);
    chk("post_after_rst", int'(reject_cnt), 0);
    chk("dt_after_rst", int'(dt), 0);

    // 65540 rejected posts -> saturation
    tk(1'b1, 1'b0);
    for (int i = 0; i < 65540; i++) tk(1'b1, 1'b1);
    chk("reject_saturate", int'(reject_cnt), 65535);

    idle(3);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stdp_dt_tracker.md
STDP_DT_TRACKER -- requirements
Module: stdp_dt_tracker

Interface
REQ-001 The block SHALL have the parameter WINDOW_MIN, default 2, the smallest accepted pre-to-post interval in ticks.
REQ-002 The block SHALL have the parameter WINDOW_MAX, default 20, the largest accepted pre-to-post interval in ticks.
REQ-003 The block SHALL have the port clk, input, 1 bit: clock, rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have the port tick, input, 1 bit: simulation time-step strobe; events are sampled only when tick=1.
REQ-006 The block SHALL have the port pre_spike, input, 1 bit: presynaptic spike for the current tick.
REQ-007 The block SHALL have the port post_spike, input, 1 bit: postsynaptic spike for the current tick.
REQ-008 The block SHALL have the port dt, output, 8 bits: registered pre-to-post interval that drives the depression LUT address.
REQ-009 The block SHALL have the port dt_valid, output, 1 bit: one-cycle pulse marking a new accepted dt.
REQ-010 The block SHALL have the port lut_valid, output, 1 bit: dt_valid delayed one cycle, aligned with the registered LUT output.
REQ-011 The block SHALL have the port reject_cnt, output, 16 bits: saturating count of post spikes that fell outside the window.

Function
REQ-012 The block SHALL implement two states: IDLE (no pending pre spike) and ARMED (pre spike pending, interval counter running).
REQ-013 On any tick with pre_spike=1, the block SHALL enter ARMED and set the interval counter to 0.
REQ-014 On a tick in ARMED with pre_spike=0, the counter SHALL increment by 1 and saturate at 255.
REQ-015 The interval n SHALL be the number of ticks between the pre tick and the post tick; a post spike one tick after the pre spike gives n=1.
REQ-016 On a tick in ARMED with post_spike=1 and WINDOW_MIN<=n<=WINDOW_MAX, the block SHALL, on the next clock edge, set dt<=n and assert dt_valid for exactly one cycle.
REQ-017 On a tick in ARMED with post_spike=1 and n outside the window, dt_valid SHALL stay 0 and reject_cnt SHALL increment, saturating at 65535.
REQ-018 After any post spike evaluated in ARMED, the block SHALL return to IDLE, so each pre spike is paired with at most one post spike.
REQ-019 A post spike in IDLE SHALL be ignored, with no dt_valid and no reject_cnt change.
REQ-020 When pre and post spikes coincide on a tick, the block SHALL first evaluate the post spike against the old state and counter, then arm a fresh interval with the counter at 0, ending in ARMED.
REQ-021 dt SHALL hold its last value while dt_valid=0.
REQ-022 lut_valid SHALL equal dt_valid registered once (latency 1 cycle).
REQ-023 pre_spike and post_spike SHALL have no effect when tick=0; the counter and state SHALL hold.
REQ-024 Ticks on back-to-back clock cycles SHALL be supported, with one event evaluation per cycle.

Reset
REQ-025 When rst=1 at a clock edge, the block SHALL set state=IDLE, counter=0, dt=0, dt_valid=0, lut_valid=0 and reset_cnt=0; this SHALL override tick and the spike inputs on the same edge.
REQ-026 Reset while ARMED SHALL discard the pending pre spike; a post spike on the first tick after reset SHALL be ignored.
REQ-027 With dt=0 after reset, the downstream LUT SHALL receive an address that maps to its zero default.

Configuration
REQ-028 With DT_TIMEOUT_EN defined, a tick in ARMED that produces n=WINDOW_MAX+1 without a post spike SHALL return the block to IDLE with no reject_cnt change; a later post spike SHALL then be ignored.
REQ-029 Without DT_TIMEOUT_EN, the block SHALL remain ARMED indefinitely, with the counter saturating at 255; a late post spike SHALL be counted in reject_cnt.

Verification
REQ-030 The bench SHALL cover: pre at tick 10, post at tick 15 -> dt=5, dt_valid for 1 cycle, lut_valid on the next cycle, state IDLE.
REQ-031 The bench SHALL cover: pre at tick 0, post at tick 1 -> no dt_valid, reject_cnt=1; post at tick 21 after a pre at tick 1 -> dt=20 accepted.
REQ-032 The bench SHALL cover: pre at tick 0, pre and post together at tick 4 -> dt=4 accepted, re-armed with counter 0; post at tick 7 -> dt=3.
REQ-033 The bench SHALL cover: pre at tick 0, post at tick 30 -> with DT_TIMEOUT_EN, no dt_valid and reject_cnt=0; without it, reject_cnt=1.
REQ-034 The bench SHALL cover: pre, then rst asserted for 1 cycle after 6 ticks, then post at tick 8 -> no dt_valid; all outputs 0 after reset.
REQ-035 The bench SHALL cover: pre_spike and post_spike pulsed with tick=0 -> no state change; 65540 out-of-window posts -> reject_cnt=65535.
